// File: rtl/rec_pkg.sv
// Shared definitions for the record stream writer.
//   - rec_state_e   : writer FSM state encoding
//   - RecDataW/...  : default sample width, RAM address width and FIFO depth
//   - fifo_depth_ok : legality check for the sample FIFO depth (power of 2, >= 2)
package rec_pkg;

  localparam int unsigned RecDataW     = 16;
  localparam int unsigned RecAddrW     = 26;
  localparam int unsigned RecFifoDepth = 8;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StSetup,
    StWrite,
    StAdvance,
    StDrain
  } rec_state_e;

  function automatic bit fifo_depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with registered read.
// Ports:
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset
//   clear_i  : discard all contents (read data register is kept)
//   push_i   : write wdata_i when not full
//   pop_i    : load head into rdata_o on the next edge when not empty
//   wdata_i  : write data
//   rdata_o  : registered read data, holds until the next pop
//   full_o   : no free entry
//   empty_o  : no stored entry
//   level_o  : number of stored entries
module sample_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW:0]     wptr_q, rptr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              push_ok, pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level_o = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = rdata_q;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdata_q <= '0;
    end else if (clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop_ok) begin
        rdata_q <= mem_q[rptr_q[PtrW-1:0]];
        rptr_q  <= rptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/record_stream_writer.sv
// Record path between the codec interface and the RAM wrapper. Codec samples are
// queued in a small FIFO and written to RAM one word at a time at addresses
// 0..max_addr. Dropped samples (FIFO full) are flagged in overflow.
// Optional feature: define REC_PEAK_METER_EN to build the peak level meter;
// otherwise peak is tied to zero.
// Ports:
//   clk, reset (sync, active-low)
//   start, stop            : one-cycle control pulses
//   sample_in/sample_valid : codec sample and strobe
//   max_addr               : last writable address, latched at start
//   ram_rdy                : RAM accepting writes
//   ram_addr/ram_data/ram_we : single-word write port
//   busy, done             : run status, done pulses on return to idle
//   mem_full, overflow     : sticky run status flags
//   last_addr              : highest address written in the last run
//   peak                   : peak absolute sample level
module record_stream_writer
  import rec_pkg::*;
#(
  parameter int unsigned DATA_W     = RecDataW,
  parameter int unsigned ADDR_W     = RecAddrW,
  parameter int unsigned FIFO_DEPTH = RecFifoDepth
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [ADDR_W-1:0] max_addr,
  input  logic              ram_rdy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  output logic              busy,
  output logic              done,
  output logic              mem_full,
  output logic              overflow,
  output logic [ADDR_W-1:0] last_addr,
  output logic [DATA_W-1:0] peak
);

  if (!fifo_depth_ok(FIFO_DEPTH)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  rec_state_e        state_q;
  logic [ADDR_W-1:0] addr_q, max_q, last_q;
  logic              we_q, busy_q, done_q, full_q, ovf_q;
  // Set once stop has been seen; from then on no sample is captured.
  logic              stop_seen_q;

  logic                        cap_en, push, push_rej, pop, fifo_clear;
  logic                        fifo_full, fifo_empty;
  logic [DATA_W-1:0]           fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  always_comb begin
    cap_en = 1'b0;
    pop    = 1'b0;
    unique case (state_q)
      StCapture: begin
        cap_en = !stop_seen_q;
        pop    = !stop && (fifo_level != '0) && ram_rdy;
      end
      StSetup, StWrite, StAdvance: cap_en = !stop_seen_q;
      StDrain:   pop = !fifo_empty && ram_rdy;
      default:   ;
    endcase
  end

  // Full is judged before any same-cycle pop.
  assign push       = sample_valid && cap_en;
  assign push_rej   = push && fifo_full;
  // Leftovers from a run ended at max_addr must not leak into the next run.
  assign fifo_clear = (state_q == StIdle) && start;

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (fifo_clear),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (sample_in),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      max_q       <= '0;
      last_q      <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      stop_seen_q <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (push_rej) begin
        ovf_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StCapture;
            busy_q      <= 1'b1;
            max_q       <= max_addr;
            addr_q      <= '0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            stop_seen_q <= 1'b0;
          end
        end
        StCapture: begin
          if (stop) begin
            state_q     <= StDrain;
            stop_seen_q <= 1'b1;
          end else if (pop) begin
            state_q <= StSetup;
          end
        end
        StSetup: begin
          we_q    <= 1'b1;
          state_q <= StWrite;
          if (stop) stop_seen_q <= 1'b1;
        end
        StWrite: begin
          last_q  <= addr_q;
          state_q <= StAdvance;
          if (stop) stop_seen_q <= 1'b1;
        end
        StAdvance: begin
          if (addr_q == max_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            full_q  <= 1'b1;
          end else begin
            addr_q      <= addr_q + 1'b1;
            stop_seen_q <= stop_seen_q || stop;
            state_q     <= (stop_seen_q || stop) ? StDrain : StCapture;
          end
        end
        StDrain: begin
          if (fifo_empty) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (pop) begin
            state_q <= StSetup;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ram_addr  = addr_q;
  assign ram_data  = fifo_rdata;
  assign ram_we    = we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_full  = full_q;
  assign overflow  = ovf_q;
  assign last_addr = last_q;

`ifdef REC_PEAK_METER_EN
  logic [DATA_W-1:0] peak_q, mag;

  // Two's-complement magnitude; the most negative code saturates.
  always_comb begin
    mag = sample_in;
    if (sample_in[DATA_W-1]) begin
      if (sample_in == {1'b1, {(DATA_W-1){1'b0}}}) begin
        mag = {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
        mag = -sample_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      peak_q <= '0;
    end else if (fifo_clear) begin
      peak_q <= '0;
    end else if (push && !fifo_full && (mag > peak_q)) begin
      peak_q <= mag;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule

// File: doc/record_stream_writer.md
# record_stream_writer

Record-path stage between the audio codec interface and the DDR RAM wrapper. Captures 16-bit codec samples on a per-sample strobe into a small FIFO. Drains the FIFO into RAM as single-word writes at sequential addresses, from 0 up to a supplied maximum address. This replaces free-running cycle-count pacing in the memory FSM: every codec sample is written exactly once, and dropped samples are flagged.

## Interface
Parameters:
- DATA_W, 16, sample and RAM word width
- ADDR_W, 26, RAM word address width
- FIFO_DEPTH, 8, sample FIFO entries; must be a power of 2, at least 2

Ports:
- clk  in  1  memory-side clock; all logic is in this domain
- reset  in  1  synchronous, active-low; one clock; reset is synchronous and active-low
- start  in  1  one-cycle pulse: begin a recording at address 0
- stop  in  1  one-cycle pulse: end capture, drain the FIFO, finish
- sample_in  in  DATA_W  two's-complement codec sample
- sample_valid  in  1  one-cycle strobe; sample_in is valid in that cycle
- max_addr  in  ADDR_W  last writable address (inclusive); sampled at start
- ram_rdy  in  1  RAM wrapper calibrated and accepting writes
- ram_addr  out  ADDR_W  write address
- ram_data  out  DATA_W  write data
- ram_we  out  1  one-cycle write pulse
- busy  out  1  high from start until return to IDLE
- done  out  1  one-cycle pulse on return to IDLE
- mem_full  out  1  sticky; last run ended by reaching max_addr
- overflow  out  1  sticky; a sample was dropped because the FIFO was full
- last_addr  out  ADDR_W  highest address written in the last run
- peak  out  DATA_W  peak absolute sample level (see Configuration)

## Operation
- Reset values: ram_addr=0, ram_data=0, ram_we=0, busy=0, done=0, mem_full=0, overflow=0, last_addr=0, peak=0. FIFO is empty and the FSM is in IDLE.
- FSM states:
  - IDLE: start → CAPTURE. Latch max_addr, clear address, mem_full, overflow and peak.
  - CAPTURE: capture enabled. FIFO non-empty and ram_rdy → SETUP. stop → DRAIN.
  - SETUP: pop FIFO head into ram_data; drive ram_addr. → WRITE.
  - WRITE: ram_we=1 for exactly this cycle; last_addr←ram_addr. → ADVANCE.
  - ADVANCE:
    - address == latched max → IDLE, set mem_full, pulse done.
    - otherwise address+1; return to CAPTURE, or to DRAIN if stop was seen.
  - DRAIN: capture disabled. FIFO empty → IDLE, pulse done. Otherwise, with ram_rdy → SETUP.
- Push rule: a sample is accepted when sample_valid=1, the FSM is in CAPTURE, SETUP, WRITE or ADVANCE before stop, and the FIFO is not full at the start of the cycle. A same-cycle pop does not free space for the push. A rejected sample sets overflow.
- Samples are never captured in IDLE or DRAIN.
- start while busy is ignored. stop in IDLE is ignored. stop in the same cycle as start is ignored (start wins).
- stop arriving during SETUP, WRITE or ADVANCE is latched and takes effect at the next state decision.
- ram_rdy low stalls only in CAPTURE and DRAIN. Once SETUP is entered, the write completes.
- Address never wraps. max_addr=0 gives exactly one write.
- Reset mid-write: ram_we is deasserted at the next edge and FIFO contents are discarded.

## Timing
- Per-write cost: 3 cycles (SETUP, WRITE, ADVANCE) plus 1 decision cycle in CAPTURE or DRAIN. Sustained rate is 1 write per 4 clocks.
- Latency, with the FIFO empty, the FSM in CAPTURE and ram_rdy=1:
  - sample_valid in cycle 0
  - SETUP in cycle 2
  - ram_we high in cycle 3, with ram_data equal to that sample
- ram_addr and ram_data are stable from SETUP through WRITE.
- done asserts in the cycle after the final ADVANCE or DRAIN exit; busy falls in the same cycle.

## Configuration
- REC_PEAK_METER_EN defined:
  - On each accepted push, peak ← max(peak, |sample_in|).
  - |−2^(DATA_W−1)| saturates to 2^(DATA_W−1)−1.
  - peak is cleared at start and held after done.
- REC_PEAK_METER_EN undefined: the peak port exists and is tied to 0; no comparator logic is built.

## Structure
- Shared package rec_pkg holds:
  - FSM state enum (IDLE, CAPTURE, SETUP, WRITE, ADVANCE, DRAIN)
  - default DATA_W and ADDR_W constants
  - the FIFO_DEPTH power-of-2 check
- One sub-module, sample_fifo: synchronous FIFO with push, pop, full, empty and a level count. Pointers are log2(FIFO_DEPTH)+1 bits wide; pop has a registered read.

## Test plan
- Basic run: start, max_addr=3, samples 0x0001..0x0004 at 1 per 20 clocks → 4 writes to addresses 0..3 with matching data; mem_full=1; done pulses once; last_addr=3.
- Stop and drain: start, max_addr=100, 10 samples, stop 1 cycle after the 10th → 10 writes to addresses 0..9; mem_full=0; no ram_we after done.
- Overflow: ram_rdy=0, start, 9 samples back-to-back, then ram_rdy=1, stop → addresses 0..7 get samples 1..8; overflow=1.
- Stall and latency: ram_rdy toggled low for 5 cycles mid-run → no ram_we while low, no data lost. Single sample with ram_rdy=1 → ram_we 3 cycles after sample_valid.
- Peak (with REC_PEAK_METER_EN): samples 0x0100, 0x8000, 0xFF00 → peak=0x7FFF. Without the macro → peak=0.
- Reset mid-run: reset low during WRITE → next edge has all outputs at reset values and the FIFO empty; a following start records from address 0.
